// File: rtl/trn_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : trn_arb
// Brief    : Token arbiter for the shared TRN endpoint. Rotation grants go to
//            masked-in channels; urgent grants are interleaved between them.
//            Optional watchdog is built when ARB_WATCHDOG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module trn_arb #(
    parameter int             NCH      = 3,
    parameter logic [NCH-1:0] RR_MASK  = 3'b011,
    parameter int             HOLDOFF  = 1,
    parameter int             WDOG_CYC = 4096
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NCH-1:0]                      drvn,
    input  logic [NCH-1:0]                      reqep,
    output logic [NCH-1:0]                      trn,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] grant_id,
    output logic                                busy,
    output logic                                wdog_err
);

    localparam int c_IDW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_GRANT  = 2'd1;
    localparam logic [1:0] c_ST_SETTLE = 2'd2;

    function automatic logic [c_IDW-1:0] f_lowest(input logic [NCH-1:0] m);
        logic [c_IDW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = c_IDW'(i);
        end
        return r;
    endfunction

    localparam logic [c_IDW-1:0] c_RR_INIT = f_lowest(RR_MASK);

    logic [1:0]       r_state;
    logic [c_IDW-1:0] r_rr_ptr;
    logic [c_IDW-1:0] r_urg_ptr;
    logic             r_urg_ok;
    logic [3:0]       r_hold_cnt;
    logic [c_IDW-1:0] r_win;
    logic [NCH-1:0]   r_trn;
    logic [c_IDW-1:0] r_grant_id;
    logic             r_busy;

    logic             w_urg_hit;
    logic [c_IDW-1:0] w_urg_win;
    logic [c_IDW-1:0] w_rr_win;
    logic [c_IDW-1:0] w_rr_next;
    logic             w_urg_allow;
    logic             w_take_urg;
    logic             w_take_rr;

    // Searches iterate from the far end so the nearest candidate wins last.
    always_comb begin
        w_urg_hit = 1'b0;
        w_urg_win = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (reqep[(int'(r_urg_ptr) + k) % NCH]) begin
                w_urg_hit = 1'b1;
                w_urg_win = c_IDW'((int'(r_urg_ptr) + k) % NCH);
            end
        end
        w_rr_win = r_rr_ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (RR_MASK[(int'(r_rr_ptr) + k) % NCH]) w_rr_win = c_IDW'((int'(r_rr_ptr) + k) % NCH);
        end
        w_rr_next = w_rr_win;
        for (int k = NCH; k >= 1; k--) begin
            if (RR_MASK[(int'(w_rr_win) + k) % NCH]) w_rr_next = c_IDW'((int'(w_rr_win) + k) % NCH);
        end
    end

    // Without a rotation set, the urgent slot is permanently open.
    assign w_urg_allow = r_urg_ok | (RR_MASK == '0);
    assign w_take_urg  = w_urg_allow & w_urg_hit;
    assign w_take_rr   = ~w_take_urg & (RR_MASK != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_rr_ptr   <= c_RR_INIT;
            r_urg_ptr  <= c_IDW'(NCH - 1);
            r_urg_ok   <= 1'b0;
            r_hold_cnt <= 4'd0;
            r_win      <= '0;
            r_trn      <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_trn  <= '0;
            r_busy <= (drvn != '0) || (r_state != c_ST_IDLE);
            case (r_state)
                c_ST_IDLE: begin
                    if (drvn == '0) begin
                        if (w_take_urg) begin
                            r_win     <= w_urg_win;
                            r_urg_ptr <= w_urg_win;
                            r_urg_ok  <= (RR_MASK == '0);
                            r_state   <= c_ST_GRANT;
                        end else if (w_take_rr) begin
                            r_win    <= w_rr_win;
                            r_rr_ptr <= w_rr_next;
                            r_urg_ok <= 1'b1;
                            r_state  <= c_ST_GRANT;
                        end
                    end
                end
                c_ST_GRANT: begin
                    r_trn      <= {{(NCH-1){1'b0}}, 1'b1} << r_win;
                    r_grant_id <= r_win;
                    r_hold_cnt <= 4'(HOLDOFF);
                    r_state    <= c_ST_SETTLE;
                end
                c_ST_SETTLE: begin
                    r_hold_cnt <= r_hold_cnt - 4'd1;
                    if (r_hold_cnt <= 4'd1) r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign trn      = r_trn;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

`ifdef ARB_WATCHDOG_EN
    localparam int c_WDW = $clog2(WDOG_CYC + 1);

    logic [c_WDW-1:0] r_wdog_cnt;
    logic             r_wdog_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else if (drvn == '0) begin
            r_wdog_cnt <= '0;
        end else if (r_wdog_cnt != c_WDW'(WDOG_CYC)) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
            if (r_wdog_cnt == c_WDW'(WDOG_CYC - 1)) r_wdog_err <= 1'b1;
        end
    end

    assign wdog_err = r_wdog_err;
`else
    logic w_unused_wdog;
    assign w_unused_wdog = (WDOG_CYC > 0);
    assign wdog_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trn_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_trn_arb
// Brief    : Scoreboard bench for trn_arb: expected grant ids are queued by the
//            stimulus and popped by per-DUT monitors on every trn pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trn_arb;

`ifdef ARB_WATCHDOG_EN
    localparam logic c_WD = 1'b1;
`else
    localparam logic c_WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_n_b;
    logic [2:0] drvn_a, reqep_a, trn_a;
    logic [1:0] gid_a;
    logic       busy_a, wdog_a;
    logic [3:0] drvn_b, reqep_b, trn_b;
    logic [1:0] gid_b;
    logic       busy_b, wdog_b;

    int q_a[$];
    int q_b[$];
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_a = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trn_arb #(.NCH(3), .RR_MASK(3'b011), .HOLDOFF(1), .WDOG_CYC(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .drvn(drvn_a), .reqep(reqep_a),
        .trn(trn_a), .grant_id(gid_a), .busy(busy_a), .wdog_err(wdog_a)
    );

    trn_arb #(.NCH(4), .RR_MASK(4'b1010), .HOLDOFF(1), .WDOG_CYC(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .drvn(drvn_b), .reqep(reqep_b),
        .trn(trn_b), .grant_id(gid_b), .busy(busy_b), .wdog_err(wdog_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        int e;
        if (!rst_n) begin
            last_a = -1;
        end else if (trn_a != 3'b000) begin
            if (q_a.size() == 0) begin
                chk("unexpected_grant_a", 32'(trn_a), 32'd0);
            end else begin
                e = q_a.pop_front();
                chk("trn_a", 32'(trn_a), 32'(1) << e);
                chk("grant_id_a", 32'(gid_a), 32'(e));
                if (last_a >= 0) chk("spacing_a_ge3", 32'(cyc - last_a >= 3), 32'd1);
                last_a = cyc;
            end
        end
    end

    always @(negedge clk) begin
        int e;
        if (rst_n_b && trn_b != 4'b0000) begin
            if (q_b.size() == 0) begin
                chk("unexpected_grant_b", 32'(trn_b), 32'd0);
            end else begin
                e = q_b.pop_front();
                chk("trn_b", 32'(trn_b), 32'(1) << e);
                chk("grant_id_b", 32'(gid_b), 32'(e));
            end
        end
    end

    task automatic wait_q_a(input int budget);
        int n = 0;
        while (q_a.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("timeout_a_pending", 32'(q_a.size()), 32'd0);
    endtask

    task automatic wait_q_b(input int budget);
        int n = 0;
        while (q_b.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("timeout_b_pending", 32'(q_b.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0; rst_n_b = 1'b0;
        drvn_a = '0; reqep_a = '0; drvn_b = '0; reqep_b = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_trn_a", 32'(trn_a), 32'd0);
        chk("reset_gid_a", 32'(gid_a), 32'd0);
        chk("reset_busy_a", 32'(busy_a), 32'd0);
        chk("reset_wdog_a", 32'(wdog_a), 32'd0);
        chk("reset_trn_b", 32'(trn_b), 32'd0);

        // plain rotation 0,1,0,1...
        q_a = '{0, 1, 0, 1, 0, 1};
        rst_n = 1'b1;
        wait_q_a(60);
        rst_n = 1'b0;
        @(negedge clk); #1;

        // urgent ch2 interleaved with rotation
        reqep_a = 3'b100;
        q_a = '{0, 2, 1, 2, 0};
        rst_n = 1'b1;
        wait_q_a(60);
        rst_n = 1'b0;
        reqep_a = '0;
        @(negedge clk); #1;

        // channel 1 holds the endpoint for 10 cycles
        q_a = '{0, 1};
        rst_n = 1'b1;
        wait_q_a(30);
        drvn_a = 3'b010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("busy_while_drvn", 32'(busy_a), 32'd1);
        end
        q_a.push_back(0);
        drvn_a = '0;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (trn_a == 3'b000 && n < 20);
        chk("drvn_release_latency", 32'(n), 32'd2);
        wait_q_a(5);
        rst_n = 1'b0;
        @(negedge clk); #1;

        // NCH=4 instance: rotation 1,3 and urgent 0,2 interleaved
        reqep_b = 4'b0101;
        q_b = '{1, 0, 3, 2, 1, 0};
        rst_n_b = 1'b1;
        wait_q_b(60);
        rst_n_b = 1'b0;
        @(negedge clk); #1;

        // asynchronous reset while trn[0] is high
        q_a = '{0};
        rst_n = 1'b1;
        wait_q_a(20);
        chk("trn0_high_before_reset", 32'(trn_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("trn_cleared_async", 32'(trn_a), 32'd0);
        @(negedge clk); #1;
        q_a = '{0};
        rst_n = 1'b1;
        wait_q_a(20);
        rst_n = 1'b0;
        @(negedge clk); #1;

        // watchdog: drvn[0] held from reset release
        drvn_a = 3'b001;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("wdog_before_threshold", 32'(wdog_a), 32'd0);
        @(posedge clk); #1;
        chk("wdog_at_threshold", 32'(wdog_a), 32'(c_WD));
        chk("busy_during_wdog", 32'(busy_a), 32'd1);
        q_a = '{0};
        drvn_a = '0;
        wait_q_a(20);
        chk("wdog_sticky", 32'(wdog_a), 32'(c_WD));
        chk("wdog_b_idle", 32'(wdog_b), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
